// File: rtl/alu_pkg.sv
// Shared constants for the 16-bit ALU datapath and its result serializer.
// Holds the state encoding, the ALU opcodes and the frame sizing helper.
package alu_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    SEND = ST_SEND
  } ser_state_e;

  localparam int BYTE_WIDTH_DEF = 8;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  function automatic int num_bytes(input int width, input int byte_width);
    return (2 * width) / byte_width;
  endfunction

endpackage

// File: rtl/alu_result_serializer.sv
// Captures each valid ALU result and streams it out LSB byte first over valid/ready.
// Results arriving mid-frame are dropped and reported with a one-cycle Overrun pulse.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int Width      = 16,
  parameter int Byte_Width = BYTE_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2*Width-1:0]    Arith_OUT,
  input  logic                  Arith_Flag,
  input  logic                  Tx_Ready,
  output logic [Byte_Width-1:0] Tx_Data,
  output logic                  Tx_Valid,
  output logic                  Tx_Last,
  output logic                  Busy,
  output logic                  Overrun
);

  localparam int Num_Bytes = num_bytes(Width, Byte_Width);
  localparam int IdxW      = (Num_Bytes > 1) ? $clog2(Num_Bytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Num_Bytes - 1);

  ser_state_e          state_q, state_d;
  logic [2*Width-1:0]  shift_q, shift_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                overrun_q, overrun_d;

  logic xfer;
  logic at_last;

  assign xfer    = (state_q == SEND) && Tx_Ready;
  assign at_last = (idx_q == LastIdx);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Arith_Flag) begin
          shift_d = Arith_OUT;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer && at_last) begin
          // A result landing on the final transfer starts the next frame with no bubble.
          if (Arith_Flag) begin
            shift_d = Arith_OUT;
          end else begin
            shift_d = shift_q >> Byte_Width;
            state_d = IDLE;
          end
          idx_d = '0;
        end else begin
          overrun_d = Arith_Flag;
          if (xfer) begin
            shift_d = shift_q >> Byte_Width;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Tx_Data  = shift_q[Byte_Width-1:0];
  assign Tx_Valid = (state_q == SEND);
  assign Busy     = (state_q == SEND);
  assign Tx_Last  = (state_q == SEND) && at_last;
  assign Overrun  = overrun_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: cycle-by-cycle vector table plus a
// randomized-backpressure sequence on a negative MUL result.
module tb_alu_result_serializer;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Arith_OUT;
  logic        Arith_Flag;
  logic        Tx_Ready;
  logic [7:0]  Tx_Data;
  logic        Tx_Valid;
  logic        Tx_Last;
  logic        Busy;
  logic        Overrun;

  int checks   = 0;
  int failures = 0;

  alu_result_serializer #(.Width(16), .Byte_Width(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Arith_OUT (Arith_OUT),
    .Arith_Flag(Arith_Flag),
    .Tx_Ready  (Tx_Ready),
    .Tx_Data   (Tx_Data),
    .Tx_Valid  (Tx_Valid),
    .Tx_Last   (Tx_Last),
    .Busy      (Busy),
    .Overrun   (Overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rst;
    logic        flag;
    logic [31:0] data;
    logic        ready;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_last;
    logic        e_busy;
    logic        e_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [1:0] op,
                                            input logic signed [15:0] a,
                                            input logic signed [15:0] b);
    logic signed [31:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      default: r = (b != 0) ? a / b : '0;
    endcase
    return r;
  endfunction

  // name, rst, flag, data, ready -> valid, data, last, busy, overrun (state after the edge)
  task automatic build_table();
    vecs.push_back('{"reset",      1, 1, 32'h12345678, 1,  0, 8'h00, 0, 0, 0});
    vecs.push_back('{"idle_hold",  0, 0, 32'h00000000, 1,  0, 8'h00, 0, 0, 0});
    vecs.push_back('{"f1_b0",      0, 1, 32'h12345678, 1,  1, 8'h78, 0, 1, 0});
    vecs.push_back('{"f1_b1",      0, 0, 32'h00000000, 1,  1, 8'h56, 0, 1, 0});
    vecs.push_back('{"f1_b2",      0, 0, 32'h00000000, 1,  1, 8'h34, 0, 1, 0});
    vecs.push_back('{"f1_b3",      0, 0, 32'h00000000, 1,  1, 8'h12, 1, 1, 0});
    vecs.push_back('{"f1_done",    0, 0, 32'h00000000, 1,  0, 8'h00, 0, 0, 0});
    vecs.push_back('{"bp_b0",      0, 1, 32'h12345678, 0,  1, 8'h78, 0, 1, 0});
    vecs.push_back('{"bp_stall1",  0, 0, 32'h00000000, 0,  1, 8'h78, 0, 1, 0});
    vecs.push_back('{"bp_stall2",  0, 0, 32'h00000000, 0,  1, 8'h78, 0, 1, 0});
    vecs.push_back('{"bp_stall3",  0, 0, 32'h00000000, 0,  1, 8'h78, 0, 1, 0});
    vecs.push_back('{"bp_b1",      0, 0, 32'h00000000, 1,  1, 8'h56, 0, 1, 0});
    vecs.push_back('{"bp_b2",      0, 0, 32'h00000000, 1,  1, 8'h34, 0, 1, 0});
    vecs.push_back('{"bp_b3",      0, 0, 32'h00000000, 1,  1, 8'h12, 1, 1, 0});
    vecs.push_back('{"bp_done",    0, 0, 32'h00000000, 1,  0, 8'h00, 0, 0, 0});
    vecs.push_back('{"b2b_a0",     0, 1, 32'h12345678, 1,  1, 8'h78, 0, 1, 0});
    vecs.push_back('{"b2b_a1",     0, 0, 32'h00000000, 1,  1, 8'h56, 0, 1, 0});
    vecs.push_back('{"b2b_a2",     0, 0, 32'h00000000, 1,  1, 8'h34, 0, 1, 0});
    vecs.push_back('{"b2b_a3",     0, 0, 32'h00000000, 1,  1, 8'h12, 1, 1, 0});
    vecs.push_back('{"b2b_b0",     0, 1, 32'hAABBCCDD, 1,  1, 8'hDD, 0, 1, 0});
    vecs.push_back('{"b2b_b1",     0, 0, 32'h00000000, 1,  1, 8'hCC, 0, 1, 0});
    vecs.push_back('{"b2b_b2",     0, 0, 32'h00000000, 1,  1, 8'hBB, 0, 1, 0});
    vecs.push_back('{"b2b_b3",     0, 0, 32'h00000000, 1,  1, 8'hAA, 1, 1, 0});
    vecs.push_back('{"b2b_done",   0, 0, 32'h00000000, 1,  0, 8'h00, 0, 0, 0});
    vecs.push_back('{"ovr_b0",     0, 1, 32'h12345678, 1,  1, 8'h78, 0, 1, 0});
    vecs.push_back('{"ovr_b1",     0, 0, 32'h00000000, 1,  1, 8'h56, 0, 1, 0});
    vecs.push_back('{"ovr_drop",   0, 1, 32'hDEADBEEF, 1,  1, 8'h34, 0, 1, 1});
    vecs.push_back('{"ovr_b3",     0, 0, 32'h00000000, 1,  1, 8'h12, 1, 1, 0});
    vecs.push_back('{"ovr_done",   0, 0, 32'h00000000, 1,  0, 8'h00, 0, 0, 0});
    vecs.push_back('{"ovr_quiet",  0, 0, 32'h00000000, 1,  0, 8'h00, 0, 0, 0});
    vecs.push_back('{"rst_b0",     0, 1, 32'h12345678, 1,  1, 8'h78, 0, 1, 0});
    vecs.push_back('{"rst_b1",     0, 0, 32'h00000000, 1,  1, 8'h56, 0, 1, 0});
    vecs.push_back('{"rst_b2",     0, 0, 32'h00000000, 1,  1, 8'h34, 0, 1, 0});
    vecs.push_back('{"rst_mid",    1, 1, 32'hDEADBEEF, 1,  0, 8'h00, 0, 0, 0});
    vecs.push_back('{"rst_n0",     0, 1, 32'h0A0B0C0D, 1,  1, 8'h0D, 0, 1, 0});
    vecs.push_back('{"rst_n1",     0, 0, 32'h00000000, 1,  1, 8'h0C, 0, 1, 0});
    vecs.push_back('{"rst_n2",     0, 0, 32'h00000000, 1,  1, 8'h0B, 0, 1, 0});
    vecs.push_back('{"rst_n3",     0, 0, 32'h00000000, 1,  1, 8'h0A, 1, 1, 0});
    vecs.push_back('{"rst_done",   0, 0, 32'h00000000, 1,  0, 8'h00, 0, 0, 0});
  endtask

  task automatic run_negative_mul();
    logic [31:0] exp_word;
    logic [7:0]  exp_byte;
    int          got;
    exp_word = alu_model(OP_MUL, -16'sd1, 16'sd2);
    check_byte("mul_model_lsb", exp_word[7:0], 8'hFE);
    Arith_OUT  = exp_word;
    Arith_Flag = 1'b1;
    Tx_Ready   = 1'b0;
    tick();
    Arith_Flag = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      if (!Tx_Valid) break;
      Tx_Ready = 1'($urandom_range(0, 1));
      if (Tx_Ready) begin
        exp_byte = exp_word[8*got +: 8];
        check_byte($sformatf("neg_b%0d", got), Tx_Data, exp_byte);
        check_bit($sformatf("neg_last%0d", got), Tx_Last, (got == 3));
        got++;
      end
      tick();
    end
    checks++;
    if (got != 4) begin
      failures++;
      $display("FAIL neg_count: got %0d words expected 4", got);
    end
    check_bit("neg_idle", Tx_Valid, 1'b0);
    check_bit("neg_busy", Busy, 1'b0);
  endtask

  initial begin
    RST        = 1'b1;
    Arith_OUT  = '0;
    Arith_Flag = 1'b0;
    Tx_Ready   = 1'b0;
    tick();
    build_table();
    foreach (vecs[i]) begin
      RST        = vecs[i].rst;
      Arith_Flag = vecs[i].flag;
      Arith_OUT  = vecs[i].data;
      Tx_Ready   = vecs[i].ready;
      tick();
      check_bit({vecs[i].name, ".valid"}, Tx_Valid, vecs[i].e_valid);
      check_byte({vecs[i].name, ".data"}, Tx_Data, vecs[i].e_data);
      check_bit({vecs[i].name, ".last"}, Tx_Last, vecs[i].e_last);
      check_bit({vecs[i].name, ".busy"}, Busy, vecs[i].e_busy);
      check_bit({vecs[i].name, ".overrun"}, Overrun, vecs[i].e_ovr);
    end
    RST        = 1'b0;
    Arith_Flag = 1'b0;
    run_negative_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
